// File: rtl/a0_trace_fifo.sv
// a0 change tracer: detects a0 changes, timestamps them and buffers them in a FWFT FIFO.
// Build option A0_TRACE_TS_EN adds the cycle counter and timestamp storage; otherwise out_ts is 0.
module a0_trace_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int TS_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [DATA_WIDTH-1:0]      a0,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [TS_WIDTH-1:0]        out_ts,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drops
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] prev_a0;
    logic                  primed;

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        capture = en && (!primed || (a0 != prev_a0));
        full    = (count == FULL_CNT);
        pop     = out_valid && out_ready;
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    assign out_valid = (count != '0);
    assign out_data  = data_mem[rd_ptr];

`ifdef A0_TRACE_TS_EN
    logic [TS_WIDTH-1:0] cycle_cnt;
    logic [TS_WIDTH-1:0] ts_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr] <= cycle_cnt;
        end
    end

    assign out_ts = ts_mem[rd_ptr];
`else
    assign out_ts = '0;
`endif

    // Storage carries no reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= a0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            prev_a0  <= '0;
            primed   <= 1'b0;
            overflow <= 1'b0;
            drops    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (en) begin
                prev_a0 <= a0;
                primed  <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drops != 8'hFF) begin
                    drops <= drops + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Self-checking bench for a0_trace_fifo against a queue-based model of the trace rules.
// Timestamp expectations follow A0_TRACE_TS_EN in the same way as the design.
module tb_a0_trace_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TW    = 16;

    logic          clk;
    logic          rst;
    logic          en;
    logic [DW-1:0] a0;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_ts;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    count;
    logic          overflow;
    logic [7:0]    drops;

    int tests;
    int fails;

    logic [DW-1:0] q_data[$];
    logic [TW-1:0] q_ts[$];
    bit            primed_m;
    logic [DW-1:0] prev_m;
    logic [TW-1:0] cyc_m;
    int            drops_m;
    bit            ovf_m;

    a0_trace_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a0        (a0),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .drops     (drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        q_data.delete();
        q_ts.delete();
        primed_m = 1'b0;
        prev_m   = '0;
        cyc_m    = '0;
        drops_m  = 0;
        ovf_m    = 1'b0;
    endtask

    task automatic do_reset();
        en        = 1'b0;
        out_ready = 1'b0;
        a0        = '0;
        rst       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock edge with the given inputs; the model applies the trace rules for that edge.
    task automatic step(input logic [DW-1:0] a, input logic e, input logic r);
        bit cap;
        bit pp;
        a0        = a;
        en        = e;
        out_ready = r;
        @(posedge clk);
        cap = e && (!primed_m || a != prev_m);
        pp  = (q_data.size() > 0) && r;
        if (pp) begin
            void'(q_data.pop_front());
            void'(q_ts.pop_front());
        end
        if (cap) begin
            if (q_data.size() < DEPTH) begin
                q_data.push_back(a);
`ifdef A0_TRACE_TS_EN
                q_ts.push_back(cyc_m);
`else
                q_ts.push_back('0);
`endif
            end else begin
                ovf_m = 1'b1;
                if (drops_m < 255) drops_m++;
            end
        end
        if (e) begin
            prev_m   = a;
            primed_m = 1'b1;
        end
        cyc_m = cyc_m + 1'b1;
        #1;
    endtask

    task automatic test_reset();
        en        = 1'b0;
        out_ready = 1'b0;
        a0        = '0;
        rst       = 1'b0;
        model_reset();
        #12;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0d exp 0", out_valid); end
        tests++;
        if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %0d exp 0", overflow); end
        tests++;
        if (drops !== 8'd0) begin fails++; $display("FAIL reset_drops got %0d exp 0", drops); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_hold_zero();
        for (int i = 0; i < 5; i++) begin
            step('0, 1'b1, 1'b0);
            tests++;
            if (count !== 4'd1) begin fails++; $display("FAIL hold_zero_count edge %0d got %0d exp 1", i, count); end
        end
        tests++;
        if (out_data !== '0 || out_ts !== '0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL hold_zero_head got data=%0d ts=%0d valid=%0d exp data=0 ts=0 valid=1",
                     out_data, out_ts, out_valid);
        end
    endtask

    task automatic test_sequence();
        logic [DW-1:0] seq [5];
        logic [TW-1:0] k;
        seq = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd3};
        k = cyc_m;
        foreach (seq[i]) step(seq[i], 1'b1, 1'b0);
        tests++;
        if (count !== 4'd4) begin fails++; $display("FAIL seq_count got %0d exp 4", count); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_data !== q_data[0] || out_ts !== q_ts[0]) begin
                fails++;
                $display("FAIL seq_entry %0d got data=%0d ts=%0d exp data=%0d ts=%0d",
                         i, out_data, out_ts, q_data[0], q_ts[0]);
            end
            if (i == 1) begin
                tests++;
`ifdef A0_TRACE_TS_EN
                if (out_data !== 32'd1 || out_ts !== k) begin
`else
                if (out_data !== 32'd1 || out_ts !== '0) begin
`endif
                    fails++;
                    $display("FAIL seq_first got data=%0d ts=%0d exp data=1 ts_base=%0d", out_data, out_ts, k);
                end
            end
            step(32'd3, 1'b1, 1'b1);
        end
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL seq_drained got %0d exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) step(32'd10 + 32'(i), 1'b1, 1'b0);
        tests++;
        if (count !== 4'd8 || overflow !== 1'b1 || drops !== 8'd1) begin
            fails++;
            $display("FAIL ovf_state got count=%0d ovf=%0d drops=%0d exp 8 1 1", count, overflow, drops);
        end
        tests++;
        if (out_data !== 32'd10) begin fails++; $display("FAIL ovf_head got %0d exp 10", out_data); end
    endtask

    task automatic test_full_pop();
        step(32'd100, 1'b1, 1'b1);
        tests++;
        if (count !== 4'd8 || drops !== 8'd1) begin
            fails++;
            $display("FAIL full_pop got count=%0d drops=%0d exp 8 1", count, drops);
        end
        tests++;
        if (out_data !== 32'd11 || out_data !== q_data[0]) begin
            fails++;
            $display("FAIL full_pop_head got %0d exp 11", out_data);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) step(32'd1000 + 32'(i), 1'b1, 1'b0);
        tests++;
        if (drops !== 8'd255 || drops_m != 255) begin
            fails++;
            $display("FAIL sat_drops got %0d exp 255", drops);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        tests++;
        if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || drops !== 8'd0) begin
            fails++;
            $display("FAIL async_reset got valid=%0d count=%0d ovf=%0d drops=%0d exp all 0",
                     out_valid, count, overflow, drops);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_en_gap();
        do_reset();
        step(32'd5, 1'b1, 1'b0);
        step(32'd6, 1'b0, 1'b0);
        step(32'd7, 1'b0, 1'b0);
        step(32'd9, 1'b0, 1'b0);
        tests++;
        if (count !== 4'd1) begin fails++; $display("FAIL en_gap_hold got %0d exp 1", count); end
        step(32'd9, 1'b1, 1'b0);
        tests++;
        if (count !== 4'd2) begin fails++; $display("FAIL en_gap_capture got %0d exp 2", count); end
        step(32'd9, 1'b1, 1'b0);
        step(32'd9, 1'b0, 1'b1);
        tests++;
        if (count !== 4'd1 || out_data !== 32'd9 || out_ts !== q_ts[0]) begin
            fails++;
            $display("FAIL en_gap_head got count=%0d data=%0d ts=%0d exp 1 9 %0d", count, out_data, out_ts, q_ts[0]);
        end
`ifndef A0_TRACE_TS_EN
        tests++;
        if (out_ts !== '0) begin fails++; $display("FAIL ts_tied got %0d exp 0", out_ts); end
`endif
    endtask

    task automatic test_random();
        logic [DW-1:0] a;
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            a = 32'($urandom_range(0, 3));
            step(a, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
            tests++;
            if (count !== 4'(q_data.size()) || out_valid !== (q_data.size() != 0) ||
                overflow !== ovf_m || drops !== 8'(drops_m) ||
                (q_data.size() != 0 && (out_data !== q_data[0] || out_ts !== q_ts[0]))) begin
                fails++;
                if (bad < 10)
                    $display("FAIL random cycle %0d got count=%0d data=%0d ts=%0d ovf=%0d drops=%0d exp count=%0d ovf=%0d drops=%0d",
                             i, count, out_data, out_ts, overflow, drops, q_data.size(), ovf_m, drops_m);
                bad++;
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_hold_zero();
        test_sequence();
        test_overflow();
        test_full_pop();
        test_saturate();
        test_en_gap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/a0_trace_fifo.md
# a0_trace_fifo

Downstream observer for the single-cycle CPU's `a0` result register. It detects every change of `a0`, timestamps it with a free-running cycle counter, and buffers the event in a small first-word-fall-through FIFO. The testbench or display driver drains the FIFO over a valid/ready handshake. Without it, fast `a0` sequences would be lost between display refreshes.

## Interface
- `DATA_WIDTH`, 32, width of `a0` and of `out_data`
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `TS_WIDTH`, 16, timestamp and cycle counter width
- `clk` input 1: sole clock; all state updates on rising edge
- `rst` input 1: reset, asynchronous, active-low; clears all state immediately
- `en` input 1: capture enable; when 0, no change detection and no push
- `a0` input DATA_WIDTH: CPU `a0` output
- `out_data` output DATA_WIDTH: `a0` value at FIFO head
- `out_ts` output TS_WIDTH: cycle count at which the head entry was captured
- `out_valid` output 1: FIFO not empty
- `out_ready` input 1: consumer accepts head when `out_valid`=1
- `count` output $clog2(DEPTH)+1: current occupancy
- `overflow` output 1: sticky; set when an event is dropped
- `drops` output 8: saturating count of dropped events

## Operation
- Reset values: `out_valid`=0, `count`=0, `overflow`=0, `drops`=0, cycle counter=0, `prev_a0`=0, `primed`=0, read/write pointers=0. `out_data`/`out_ts` are don't-care while `out_valid`=0.
- Cycle counter: increments every edge regardless of `en`, wraps 2^TS_WIDTH−1 → 0.
- Capture event on an edge with `en`=1:
  - if `primed`=0: unconditional capture, then `primed`←1
  - else: capture only if `a0` ≠ `prev_a0`
- `prev_a0` ← `a0` on every edge with `en`=1. It holds while `en`=0, so a change made during `en`=0 is detected when `en` returns to 1.
- Push writes {`a0`, current counter value} at the write pointer.
- Pop occurs on an edge with `out_valid`=1 and `out_ready`=1. It advances the read pointer.
- Full (`count`=DEPTH):
  - event with no simultaneous pop: event dropped, `overflow`←1, `drops` increments and saturates at 255
  - event with simultaneous pop: both happen, `count` unchanged, no drop
- Empty: `out_ready` ignored, and no pop occurs.
- Push and pop together when not full or empty: `count` unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is tracked separately to distinguish full from empty.
- `overflow`/`drops` clear only on reset.
- Reset asserted mid-operation: FIFO contents discarded, and all outputs return to their reset values asynchronously.

## Timing
- Capture latency: an event on edge k makes the entry visible at the head with `out_valid`=1 immediately after edge k, provided the FIFO was empty. `out_ts` holds the counter value sampled before edge k's increment.
- First-word-fall-through: head data is combinational from storage. No read latency.
- Throughput: one push and one pop per cycle.
- After reset release, the first edge with `en`=1 captures. Release is assumed synchronous to `clk` at system level.

## Configuration
- `A0_TRACE_TS_EN` defined: cycle counter and timestamp storage are present, and `out_ts` behaves as described above.
- Not defined: counter and timestamp storage are removed, and `out_ts` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then `en`=1 with `a0`=0 held for 5 edges -> exactly one entry {0, ts=0}. `count`=1 after the first edge and stays 1.
- `a0` sequence 1, 1, 2, 3, 3 on successive edges after the first capture, with `out_ready`=0 -> entries 1, 2, 3 with ts values k, k+2, k+3. `count`=4.
- Nine distinct `a0` values with DEPTH=8 and `out_ready`=0 -> `count`=8, `overflow`=1, `drops`=1. Head is still the first value.
- FIFO full, then a new `a0` and `out_ready`=1 on the same edge -> no drop, `count` stays 8, and the head advances.
- 300 overflow events -> `drops`=255 (saturated). Then assert `rst`=0 mid-cycle -> `out_valid`, `count`, `overflow`, and `drops` go to 0 before the next edge.
- `en`=0 while `a0` changes 5→9, then `en`=1 -> one capture of 9 on the first enabled edge. Without `A0_TRACE_TS_EN`, `out_ts`=0 throughout.
